// File: rtl/fp_compare_pipe_if.sv
// Handshake and result bundle for the pipelined IEEE-754 comparator.
// The master side drives the operands and accepts the results.
interface fp_compare_pipe_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic         signaling;
  logic         out_valid;
  logic         out_ready;
  logic         lt;
  logic         eq;
  logic         gt;
  logic         un;
  logic         cond;
  logic [W-1:0] min_out;
  logic [W-1:0] max_out;
  logic         invalid;
  logic         clear_flags;
  logic         invalid_sticky;

  modport master (
    output in_valid, a, b, op, signaling,
    output out_ready, clear_flags,
    input  in_ready, out_valid,
    input  lt, eq, gt, un, cond,
    input  min_out, max_out,
    input  invalid, invalid_sticky
  );

  modport slave (
    input  in_valid, a, b, op, signaling,
    input  out_ready, clear_flags,
    output in_ready, out_valid,
    output lt, eq, gt, un, cond,
    output min_out, max_out,
    output invalid, invalid_sticky
  );
endinterface

// File: rtl/fp_compare_pipe.sv
// Two-stage IEEE-754 comparator: relation flags, predicate,
// minNum/maxNum and invalid-operation with a sticky copy.
module fp_compare_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic               clk,
  input  logic               reset,
  fp_compare_pipe_if.slave   bus
);
  localparam int W = 1 + EXP_W + FRAC_W;
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  // {nan, snan, zero}
  function automatic logic [2:0] classify(
    input logic [W-1:0] x
  );
    logic e1;
    logic ez;
    logic fz;
    logic nan;
    e1  = &x[W-2:FRAC_W];
    ez  = ~|x[W-2:FRAC_W];
    fz  = ~|x[FRAC_W-1:0];
    nan = e1 & ~fz;
    return {nan, nan & ~x[FRAC_W-1], ez & fz};
  endfunction

  logic         r_s1_valid;
  logic [W-1:0] r_s1_a;
  logic [W-1:0] r_s1_b;
  logic [1:0]   r_s1_op;
  logic         r_s1_sig;
  logic [2:0]   r_s1_ca;
  logic [2:0]   r_s1_cb;

  logic         r_s2_valid;
  logic         r_lt;
  logic         r_eq;
  logic         r_gt;
  logic         r_un;
  logic         r_cond;
  logic [W-1:0] r_min;
  logic [W-1:0] r_max;
  logic         r_inv;
  logic         r_sticky;

  logic         w_s2_adv;
  logic         w_s1_adv;
  logic         w_lt;
  logic         w_eq;
  logic         w_gt;
  logic         w_un;
  logic         w_cond;
  logic [W-1:0] w_min;
  logic [W-1:0] w_max;
  logic         w_inv;
  logic         w_a_nan;
  logic         w_b_nan;
  logic         w_mag_gt;

  assign w_s2_adv = ~r_s2_valid | bus.out_ready;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;

  always_comb begin
    w_lt     = 1'b0;
    w_eq     = 1'b0;
    w_gt     = 1'b0;
    w_un     = 1'b0;
    w_cond   = 1'b0;
    w_min    = r_s1_a;
    w_max    = r_s1_a;
    w_a_nan  = r_s1_ca[2];
    w_b_nan  = r_s1_cb[2];
    w_mag_gt = r_s1_a[W-2:0] > r_s1_b[W-2:0];
    w_inv    = r_s1_ca[1] | r_s1_cb[1] |
               (r_s1_sig & (w_a_nan | w_b_nan));

    if (w_a_nan | w_b_nan)
      w_un = 1'b1;
    else if ((r_s1_ca[0] & r_s1_cb[0]) |
             (r_s1_a == r_s1_b))
      w_eq = 1'b1;
    else if (r_s1_a[W-1] != r_s1_b[W-1]) begin
      w_lt = r_s1_a[W-1];
      w_gt = ~r_s1_a[W-1];
    end else begin
      w_gt = w_mag_gt ^ r_s1_a[W-1];
      w_lt = ~w_gt;
    end

    unique case (r_s1_op)
      2'b00: w_cond = w_eq;
      2'b01: w_cond = w_lt;
      2'b10: w_cond = w_lt | w_eq;
      2'b11: w_cond = w_un;
    endcase

    // Signed zeros order as -0 < +0 for min/max only.
    if (w_a_nan & w_b_nan) begin
      w_min = QNAN;
      w_max = QNAN;
    end else if (w_a_nan) begin
      w_min = r_s1_b;
      w_max = r_s1_b;
    end else if (w_b_nan) begin
      w_min = r_s1_a;
      w_max = r_s1_a;
    end else if (r_s1_ca[0] & r_s1_cb[0]) begin
      w_min = r_s1_a[W-1] ? r_s1_a : r_s1_b;
      w_max = r_s1_a[W-1] ? r_s1_b : r_s1_a;
    end else if (w_lt) begin
      w_min = r_s1_a;
      w_max = r_s1_b;
    end else if (w_gt) begin
      w_min = r_s1_b;
      w_max = r_s1_a;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
      r_s1_sig   <= 1'b0;
      r_s1_ca    <= '0;
      r_s1_cb    <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_a   <= bus.a;
        r_s1_b   <= bus.b;
        r_s1_op  <= bus.op;
        r_s1_sig <= bus.signaling;
        r_s1_ca  <= classify(bus.a);
        r_s1_cb  <= classify(bus.b);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_lt       <= 1'b0;
      r_eq       <= 1'b0;
      r_gt       <= 1'b0;
      r_un       <= 1'b0;
      r_cond     <= 1'b0;
      r_min      <= '0;
      r_max      <= '0;
      r_inv      <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_lt   <= w_lt;
        r_eq   <= w_eq;
        r_gt   <= w_gt;
        r_un   <= w_un;
        r_cond <= w_cond;
        r_min  <= w_min;
        r_max  <= w_max;
        r_inv  <= w_inv;
      end
    end
  end

  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_sticky <= 1'b0;
    else if (r_s2_valid & bus.out_ready & r_inv)
      r_sticky <= 1'b1;
    else if (bus.clear_flags)
      r_sticky <= 1'b0;
  end

  assign bus.in_ready       = w_s1_adv;
  assign bus.out_valid      = r_s2_valid;
  assign bus.lt             = r_lt;
  assign bus.eq             = r_eq;
  assign bus.gt             = r_gt;
  assign bus.un             = r_un;
  assign bus.cond           = r_cond;
  assign bus.min_out        = r_min;
  assign bus.max_out        = r_max;
  assign bus.invalid        = r_inv;
  assign bus.invalid_sticky = r_sticky;
endmodule

// File: tb/tb_fp_compare_pipe.sv
// Directed vector bench for fp_compare_pipe (single precision).
// Covers relations, min/max, invalid, sticky, stall and reset.
module tb_fp_compare_pipe;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        sig;
    logic [3:0]  rel;
    logic        cond;
    logic [31:0] mn;
    logic [31:0] mx;
    logic        inv;
  } vec_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  vec_t tv [12];

  fp_compare_pipe_if #(.EXP_W(8), .FRAC_W(23)) bus ();

  fp_compare_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [31:0] a, input logic [31:0] b,
    input logic [1:0] op, input logic sig,
    input logic [3:0] rel, input logic cond,
    input logic [31:0] mn, input logic [31:0] mx,
    input logic inv
  );
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.sig = sig;
    v.rel = rel; v.cond = cond;
    v.mn = mn; v.mx = mx; v.inv = inv;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.a         = v.a;
    bus.b         = v.b;
    bus.op        = v.op;
    bus.signaling = v.sig;
  endtask

  task automatic chk_out(input string nm, input vec_t v);
    chk({nm, " rel"},
        {bus.lt, bus.eq, bus.gt, bus.un}, v.rel);
    chk({nm, " cond"}, bus.cond, v.cond);
    chk({nm, " min"}, bus.min_out, v.mn);
    chk({nm, " max"}, bus.max_out, v.mx);
    chk({nm, " inv"}, bus.invalid, v.inv);
  endtask

  // Issue one vector and check the 2-edge latency.
  task automatic run_vec(input int i);
    string nm;
    nm = $sformatf("v%0d", i);
    drive(tv[i]);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk({nm, " in_ready"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({nm, " early"}, bus.out_valid, 0);
    @(posedge clk); #1;
    chk({nm, " out_valid"}, bus.out_valid, 1);
    chk_out(nm, tv[i]);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " out_valid"}, bus.out_valid, 0);
    chk({nm, " in_ready"}, bus.in_ready, 1);
    chk({nm, " flags"},
        {bus.lt, bus.eq, bus.gt, bus.un, bus.cond,
         bus.invalid}, 0);
    chk({nm, " min"}, bus.min_out, 0);
    chk({nm, " max"}, bus.max_out, 0);
  endtask

  initial begin
    int ids [4];
    int sent;
    int got;
    int cyc;
    logic acc;
    logic fire;

    n_chk  = 0;
    n_fail = 0;
    // rel = {lt, eq, gt, un}
    tv[0]  = mk(32'h3F800000, 32'h40000000, 2'b01, 0,
                4'b1000, 1, 32'h3F800000, 32'h40000000, 0);
    tv[1]  = mk(32'h80000000, 32'h00000000, 2'b00, 0,
                4'b0100, 1, 32'h80000000, 32'h00000000, 0);
    tv[2]  = mk(32'h00000000, 32'h80000000, 2'b00, 0,
                4'b0100, 1, 32'h80000000, 32'h00000000, 0);
    tv[3]  = mk(32'h7FC00000, 32'hBF800000, 2'b11, 0,
                4'b0001, 1, 32'hBF800000, 32'hBF800000, 0);
    tv[4]  = mk(32'h7FC00000, 32'hBF800000, 2'b11, 1,
                4'b0001, 1, 32'hBF800000, 32'hBF800000, 1);
    tv[5]  = mk(32'h7F800001, 32'h7FC00000, 2'b00, 0,
                4'b0001, 0, 32'h7FC00000, 32'h7FC00000, 1);
    tv[6]  = mk(32'h00000001, 32'h80000001, 2'b01, 0,
                4'b0010, 0, 32'h80000001, 32'h00000001, 0);
    tv[7]  = mk(32'h7F800000, 32'h7F7FFFFF, 2'b10, 0,
                4'b0010, 0, 32'h7F7FFFFF, 32'h7F800000, 0);
    tv[8]  = mk(32'hC0000000, 32'hBF800000, 2'b10, 0,
                4'b1000, 1, 32'hC0000000, 32'hBF800000, 0);
    tv[9]  = mk(32'h3F800000, 32'h3F800000, 2'b10, 0,
                4'b0100, 1, 32'h3F800000, 32'h3F800000, 0);
    tv[10] = mk(32'h7F800001, 32'h3F800000, 2'b00, 0,
                4'b0001, 0, 32'h3F800000, 32'h3F800000, 1);
    tv[11] = mk(32'h7FC00000, 32'h7FC00001, 2'b11, 0,
                4'b0001, 1, 32'h7FC00000, 32'h7FC00000, 0);

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.clear_flags = 1'b0;
    drive(tv[0]);
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset sticky", bus.invalid_sticky, 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(i);

    // Sticky: signaling qNaN compare leaves the flag set.
    run_vec(4);
    @(posedge clk); #1;
    chk("sticky set", bus.invalid_sticky, 1);

    // Clear coinciding with a set leaves the flag at 1.
    bus.clear_flags = 1'b1;
    @(posedge clk); #1;
    bus.clear_flags = 1'b0;
    chk("sticky clr", bus.invalid_sticky, 0);
    drive(tv[5]);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("sticky pre", bus.invalid_sticky, 0);
    bus.clear_flags = 1'b1;
    @(posedge clk); #1;
    chk("sticky set+clr", bus.invalid_sticky, 1);
    @(posedge clk); #1;
    bus.clear_flags = 1'b0;
    chk("sticky clr2", bus.invalid_sticky, 0);

    // Back-to-back issue with out_ready held high.
    drive(tv[6]);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    drive(tv[7]);
    chk("b2b early", bus.out_valid, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b2b valid0", bus.out_valid, 1);
    chk_out("b2b0", tv[6]);
    @(posedge clk); #1;
    chk("b2b valid1", bus.out_valid, 1);
    chk_out("b2b1", tv[7]);
    @(posedge clk); #1;
    chk("b2b drain", bus.out_valid, 0);

    // Four pairs against a 3-cycle output stall.
    ids = '{0, 6, 7, 8};
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 40) begin
      bus.out_ready = (cyc >= 5);
      bus.in_valid = (sent < 4);
      if (sent < 4) drive(tv[ids[sent]]);
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        chk($sformatf("stall%0d in_ready", cyc),
            bus.in_ready, 0);
        chk($sformatf("stall%0d valid", cyc),
            bus.out_valid, 1);
        chk_out($sformatf("stall%0d", cyc), tv[ids[0]]);
      end
      acc  = bus.in_valid & bus.in_ready;
      fire = bus.out_valid & bus.out_ready;
      if (fire) begin
        chk_out($sformatf("strm%0d", got), tv[ids[got]]);
        got++;
      end
      @(posedge clk);
      if (acc) sent++;
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("strm sent", sent, 4);
    chk("strm got", got, 4);
    #1;
    chk("strm drain", bus.out_valid, 0);

    // Reset with two transactions in flight.
    bus.out_ready = 1'b0;
    drive(tv[0]);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    drive(tv[6]);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("flight valid", bus.out_valid, 1);
    chk("flight ready", bus.in_ready, 0);
    reset = 1'b1;
    #1;
    chk_zero("mid reset");
    @(posedge clk); #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post reset %0d", k),
          bus.out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_compare_pipe.md
Name: fp_compare_pipe

Overview:
Parametrised, 2-stage pipelined IEEE-754 comparator for the FPU (c.cond.fmt, min/max). Exponent and fraction widths are configurable. It uses a valid/ready handshake on both sides and produces four exclusive relation flags, a MIPS-style condition bit, minNum/maxNum results and invalid-operation flags. A sticky invalid flag is kept for the FCSR.

Parameters:
EXP_W, 8, exponent field width (≥2)
FRAC_W, 23, fraction field width (≥2)
W (localparam), 1+EXP_W+FRAC_W, operand width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
in_valid  in  1  operands presented
in_ready  out  1  block can accept this cycle
a  in  W  operand A
b  in  W  operand B
op  in  2  predicate: 00 EQ, 01 LT, 10 LE, 11 UN
signaling  in  1  1 = signaling compare (any NaN raises invalid)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
lt, eq, gt, un  out  1 each  relation A?B; exactly one high when out_valid
cond  out  1  predicate result per op
min_out  out  W  minNum(a,b)
max_out  out  W  maxNum(a,b)
invalid  out  1  invalid-operation for this result
clear_flags  in  1  clears invalid_sticky
invalid_sticky  out  1  accumulated invalid

Behaviour:
- Classification:
  - NaN: exp all-ones and frac≠0. qNaN: frac MSB=1. sNaN: frac MSB=0.
  - Inf: exp all-ones and frac=0.
  - Zero: exp=0 and frac=0.
  - Subnormals are compared exactly; no flushing.
- Relation:
  - If either operand is NaN, un=1.
  - Else if both are zero (any signs), eq=1.
  - Else if a==b bitwise, eq=1.
  - Else if signs differ, the negative operand is less.
  - Else compare magnitude {exp,frac} as unsigned. Both positive: larger magnitude is gt. Both negative: result reversed.
- cond:
  - EQ: eq
  - LT: lt
  - LE: lt|eq
  - UN: un
- min/max:
  - Exactly one NaN: both outputs = the non-NaN operand.
  - Both NaN: both outputs = canonical qNaN {0, all-ones exp, 1, zeros}.
  - min(+0,-0) = -0 and max = +0, in either order.
  - Otherwise select by relation; on eq return a.
- invalid = any sNaN | (signaling & any NaN).
- Pipeline:
  - S1 registers operands, op, signaling and classification.
  - S2 registers all outputs.
  - A transaction accepted at edge N (in_valid & in_ready) gives out_valid=1 after edge N+1. Latency is 2 edges.
  - Throughput is 1 per cycle while out_ready=1.
- Handshake:
  - S2 advances when !s2_valid | out_ready.
  - S1 advances when !s1_valid | S2 advances.
  - in_ready = !s1_valid | S2 advances (combinational).
  - When out_valid & !out_ready, all outputs hold stable and no transaction is lost or duplicated.
  - Operands are sampled only on acceptance.
- Sticky flag:
  - invalid_sticky is set at an edge where out_valid & out_ready & invalid.
  - clear_flags clears it at the edge.
  - Clear and a set in the same cycle: the flag ends 1.
- Reset:
  - Clears s1_valid, s2_valid, invalid_sticky and every output register to 0 (relation flags, cond, min/max, invalid).
  - in_ready=1 while in reset and after it.
  - Reset mid-operation discards in-flight transactions; no out_valid follows.
- Relation flags and cond are qualified only by out_valid.

Test Plan:
- a=0x3F800000 (1.0), b=0x40000000 (2.0), op=01 → lt=1, cond=1, min=0x3F800000, max=0x40000000, invalid=0, out_valid 2 edges after accept.
- a=0x80000000 (-0), b=0x00000000, op=00 → eq=1, cond=1, min=0x80000000, max=0x00000000. Swapped operands give the same min/max.
- a=0x7FC00000 (qNaN), b=0xBF800000, signaling=0, op=11 → un=1, cond=1, invalid=0, min=max=0xBF800000. Same with signaling=1 → invalid=1, invalid_sticky=1 after handshake.
- a=0x7F800001 (sNaN), b=0x7FC00000, op=00 → un=1, cond=0, invalid=1, min=max=0x7FC00000. Assert clear_flags the same cycle → sticky stays 1; the next cycle's clear → 0.
- a=0x00000001 (denormal), b=0x80000001; then a=0x7F800000 (+inf), b=0x7F7FFFFF → gt=1 in both cases. Back-to-back issue with out_ready=1 gives one result per cycle.
- Stream 4 operand pairs with out_ready=0 for 3 cycles: in_ready drops after 2 accepts, outputs hold, results emerge in order with none lost. Assert reset with 2 in flight → out_valid=0, outputs=0, in_ready=1.
